// File: rtl/placement_readback.sv
// Scans finished placement out of the position/grid RAMs, cross-checks each node
// against its grid cell and streams (node, x, y, status) records over valid/ready.
module placement_readback #(
    parameter int N       = 10,
    parameter int N_NODES = 64,
    parameter int DW      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rePX,
    output logic [DW-1:0]        addrPX,
    input  logic signed [DW-1:0] doutPX,
    output logic                 rePY,
    output logic [DW-1:0]        addrPY,
    input  logic signed [DW-1:0] doutPY,
    output logic                 reGrid,
    output logic [DW-1:0]        addrGrid,
    input  logic signed [DW-1:0] doutGrid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_node,
    output logic signed [DW-1:0] out_x,
    output logic signed [DW-1:0] out_y,
    output logic [1:0]           out_status,
    output logic [DW-1:0]        unplaced_cnt,
    output logic [DW-1:0]        mismatch_cnt,
    output logic [DW-1:0]        range_cnt
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] RD_POS    = 4'd1;
    localparam logic [3:0] WAIT_POS  = 4'd2;
    localparam logic [3:0] CHK_POS   = 4'd3;
    localparam logic [3:0] RD_GRID   = 4'd4;
    localparam logic [3:0] WAIT_GRID = 4'd5;
    localparam logic [3:0] CHK_GRID  = 4'd6;
    localparam logic [3:0] EMIT      = 4'd7;
    localparam logic [3:0] NEXT      = 4'd8;
    localparam logic [3:0] DONE_ST   = 4'd9;

    localparam logic signed [DW-1:0] GRID_MAX  = DW'(N - 1);
    localparam logic signed [DW-1:0] GRID_SIDE = DW'(N);
    localparam logic [DW-1:0]        LAST_NODE = DW'(N_NODES - 1);
    localparam logic [DW-1:0]        ONE       = DW'(1);

    logic [3:0]           state;
    logic [DW-1:0]        node;
    logic signed [DW-1:0] pos_x;
    logic signed [DW-1:0] pos_y;

    function automatic logic in_grid(input logic signed [DW-1:0] v);
        return !v[DW-1] && (v <= GRID_MAX);
    endfunction

    // Strobes are decoded from state so each is a single-cycle pulse.
    assign rePX   = (state == RD_POS);
    assign rePY   = (state == RD_POS);
    assign reGrid = (state == RD_GRID);
    assign done   = (state == DONE_ST);
    assign addrPX = node;
    assign addrPY = node;

    always_ff @(posedge clk) begin
        if (state == CHK_POS) begin
            pos_x <= doutPX;
            pos_y <= doutPY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            node         <= '0;
            addrGrid     <= '0;
            out_valid    <= 1'b0;
            out_node     <= '0;
            out_x        <= '0;
            out_y        <= '0;
            out_status   <= 2'd0;
            unplaced_cnt <= '0;
            mismatch_cnt <= '0;
            range_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        unplaced_cnt <= '0;
                        mismatch_cnt <= '0;
                        range_cnt    <= '0;
                        node         <= '0;
                        busy         <= 1'b1;
                        state        <= RD_POS;
                    end
                end
                RD_POS:   state <= WAIT_POS;
                WAIT_POS: state <= CHK_POS;
                CHK_POS: begin
                    if (doutPX == '1) begin
                        unplaced_cnt <= unplaced_cnt + ONE;
                        state        <= NEXT;
                    end else if (!in_grid(doutPX) || !in_grid(doutPY)) begin
                        // Out-of-range positions skip the grid read entirely.
                        out_valid  <= 1'b1;
                        out_node   <= node;
                        out_x      <= doutPX;
                        out_y      <= doutPY;
                        out_status <= 2'd2;
                        state      <= EMIT;
                    end else begin
                        addrGrid <= DW'(doutPX * GRID_SIDE + doutPY);
                        state    <= RD_GRID;
                    end
                end
                RD_GRID:   state <= WAIT_GRID;
                WAIT_GRID: state <= CHK_GRID;
                CHK_GRID: begin
                    out_valid  <= 1'b1;
                    out_node   <= node;
                    out_x      <= pos_x;
                    out_y      <= pos_y;
                    out_status <= (doutGrid == $signed(node)) ? 2'd0 : 2'd1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_status == 2'd1) mismatch_cnt <= mismatch_cnt + ONE;
                        if (out_status == 2'd2) range_cnt <= range_cnt + ONE;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (node == LAST_NODE) begin
                        state <= DONE_ST;
                    end else begin
                        node  <= node + ONE;
                        state <= RD_POS;
                    end
                end
                DONE_ST: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_placement_readback.sv
// Bench for placement_readback: RAM models, a record-level reference model and
// directed plus randomized scans with backpressure, reset and start-while-busy.
`timescale 1ns/1ps
module tb_placement_readback;
    localparam int N  = 10;
    localparam int NN = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset, start, busy, done;
    logic rePX, rePY, reGrid, out_valid, out_ready;
    logic [DW-1:0] addrPX, addrPY, addrGrid, out_node;
    logic signed [DW-1:0] doutPX, doutPY, doutGrid, out_x, out_y;
    logic [1:0] out_status;
    logic [DW-1:0] unplaced_cnt, mismatch_cnt, range_cnt;

    always #5 clk = ~clk;

    placement_readback #(.N(N), .N_NODES(NN), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rePX(rePX), .addrPX(addrPX), .doutPX(doutPX),
        .rePY(rePY), .addrPY(addrPY), .doutPY(doutPY),
        .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
        .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
        .out_x(out_x), .out_y(out_y), .out_status(out_status),
        .unplaced_cnt(unplaced_cnt), .mismatch_cnt(mismatch_cnt), .range_cnt(range_cnt)
    );

    int posx [NN];
    int posy [NN];
    int grid [N*N];

    // Two-stage RAM: strobe/address registered, then registered read.
    logic re1_px, re1_py, re1_g;
    logic [DW-1:0] a1_px, a1_py, a1_g;
    always @(posedge clk) begin
        re1_px <= rePX; a1_px <= addrPX;
        re1_py <= rePY; a1_py <= addrPY;
        re1_g  <= reGrid; a1_g <= addrGrid;
        if (re1_px) doutPX <= (a1_px < NN) ? posx[a1_px] : -1;
        if (re1_py) doutPY <= (a1_py < NN) ? posy[a1_py] : -1;
        if (re1_g)  doutGrid <= (a1_g < N*N) ? grid[a1_g] : -1;
    end

    typedef struct { int node; int x; int y; int st; } rec_t;
    rec_t exp_q[$];
    int e_unpl, e_mis, e_rng, e_grd;
    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected record list and counters straight from the rules.
    task automatic build_model();
        int st;
        exp_q.delete();
        e_unpl = 0; e_mis = 0; e_rng = 0; e_grd = 0;
        for (int n = 0; n < NN; n++) begin
            if (posx[n] == -1) begin
                e_unpl++;
            end else if (posx[n] < 0 || posx[n] >= N || posy[n] < 0 || posy[n] >= N) begin
                exp_q.push_back('{n, posx[n], posy[n], 2});
                e_rng++;
            end else begin
                e_grd++;
                st = (grid[posx[n]*N + posy[n]] == n) ? 0 : 1;
                if (st == 1) e_mis++;
                exp_q.push_back('{n, posx[n], posy[n], st});
            end
        end
    endtask

    task automatic set_base();
        for (int i = 0; i < N*N; i++) grid[i] = -1;
        posx = '{0, 3, 9, -1};
        posy = '{0, 4, 9, 0};
        grid[0] = 0; grid[34] = 1; grid[99] = 2;
    endtask

    task automatic set_random();
        int k;
        for (int i = 0; i < N*N; i++) grid[i] = int'($urandom_range(0, 5)) - 1;
        for (int n = 0; n < NN; n++) begin
            k = $urandom_range(0, 5);
            posx[n] = $urandom_range(0, N-1);
            posy[n] = $urandom_range(0, N-1);
            if (k == 0) posx[n] = -1;
            else if (k == 1) posx[n] = N + int'($urandom_range(0, 3));
            else if (k == 2) posy[n] = -1 - int'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 1) grid[posx[n]*N + posy[n]] = n;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctrl"}, {busy, done, out_valid, rePX, rePY, reGrid}, 0);
        chk({tag, "_addr"}, {addrPX, addrPY, addrGrid}, 0);
        chk({tag, "_out"}, {out_node, out_x, out_y, out_status}, 0);
        chk({tag, "_cnt"}, {unplaced_cnt, mismatch_cnt, range_cnt}, 0);
    endtask

    // mode: 0 always ready, 1 random ready, 2 hold ready low for 5 valid cycles
    task automatic run_scan(input string tag, input int mode, input bit poke);
        int cyc, dones, got, low, stab_err, greads, px_bad, post;
        bit seen_done, stall_prev;
        logic [97:0] prev_f;
        build_model();
        cyc = 0; dones = 0; got = 0; low = 0; stab_err = 0; greads = 0;
        px_bad = 0; post = 0; seen_done = 0; stall_prev = 0; prev_f = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        while (post < 6 && cyc < 3000) begin
            start = poke && (cyc == 12 || cyc == 20);
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && low < 5) begin out_ready = 1'b0; low++; end
            else out_ready = 1'b1;
            if (stall_prev && (!out_valid || {out_node, out_x, out_y, out_status} !== prev_f))
                stab_err++;
            if (reGrid) greads++;
            if (rePX && out_valid) px_bad++;
            if (done) dones++;
            if (out_valid && out_ready) begin
                if (got < exp_q.size()) begin
                    chk({tag, "_node"}, out_node, exp_q[got].node);
                    chk({tag, "_x"}, out_x, exp_q[got].x);
                    chk({tag, "_y"}, out_y, exp_q[got].y);
                    chk({tag, "_status"}, out_status, exp_q[got].st);
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            prev_f = {out_node, out_x, out_y, out_status};
            if (seen_done) post++;
            if (done) seen_done = 1'b1;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen_done, 1);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_records"}, got, exp_q.size());
        chk({tag, "_unplaced"}, unplaced_cnt, e_unpl);
        chk({tag, "_mismatch"}, mismatch_cnt, e_mis);
        chk({tag, "_range"}, range_cnt, e_rng);
        chk({tag, "_grid_reads"}, greads, e_grd);
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_no_read_in_emit"}, px_bad, 0);
        if (mode == 2) chk({tag, "_stall_cycles"}, low, 5);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        set_base();
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_reset", busy, 0);

        set_base();
        run_scan("t1_basic", 0, 1'b0);

        set_base(); grid[34] = 5;
        run_scan("t2_mismatch", 0, 1'b0);

        set_base(); posx[0] = 10; posy[0] = 2;
        run_scan("t3_x_range", 0, 1'b0);
        set_base(); posx[0] = 2; posy[0] = -3;
        run_scan("t3_y_range", 0, 1'b0);

        set_base();
        run_scan("t4_backpressure", 2, 1'b0);

        set_base(); grid[34] = 5;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!reGrid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t5_reach_grid", reGrid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t5_abort");
        reset = 1'b0;
        set_base();
        run_scan("t5_rescan", 0, 1'b0);

        set_base();
        run_scan("t6_start_busy", 0, 1'b1);

        for (int it = 0; it < 6; it++) begin
            set_random();
            run_scan("rand", 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
